stream_packer: RTL and testbench

Upstream feeder for the synchronous FIFO. It accepts narrow words over a valid/ready stream and packs RATIO of them, little-endian, into one wide word. Each packed word is pushed into the FIFO through its push/full port, together with a lane count. A flush request forces out a partially filled word, so a producer can close a packet without padding it.

---
 rtl/stream_packer_if.sv | 28 ++
 rtl/stream_packer.sv | 85 ++++++++
 tb/tb_stream_packer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_packer_if.sv
// Narrow producer stream in, packed-word push port out, plus packer status.
// The packer takes the slave view; the producer/FIFO side takes the master view.
interface stream_packer_if #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4
);
   localparam int CW = $clog2(RATIO + 1);

   logic                      in_valid;
   logic [IN_WIDTH-1:0]       in_data;
   logic                      in_ready;
   logic                      flush;
   logic                      fifo_push;
   logic [IN_WIDTH*RATIO-1:0] fifo_wdata;
   logic [CW-1:0]             fifo_cnt;
   logic                      fifo_full;
   logic                      busy;

   modport master (
      output in_valid, in_data, flush, fifo_full,
      input  in_ready, fifo_push, fifo_wdata, fifo_cnt, busy
   );

   modport slave (
      input  in_valid, in_data, flush, fifo_full,
      output in_ready, fifo_push, fifo_wdata, fifo_cnt, busy
   );
endinterface

// File: rtl/stream_packer.sv
// Packs RATIO narrow words LSB-first into one FIFO word; push one cycle after the last word or a flush.
// A full FIFO parks the word in the hold slot; in_ready drops once the accumulator is also full or a flush waits.
module stream_packer #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4
) (
   input  logic            clk,
   input  logic            rst,
   stream_packer_if.slave  bus
);
   localparam int             CW       = $clog2(RATIO + 1);
   localparam int             WW       = IN_WIDTH * RATIO;
   localparam logic [CW-1:0]  FULL_CNT = CW'(RATIO);

   logic [WW-1:0] acc;
   logic [WW-1:0] acc_after;
   logic [WW-1:0] hold_data;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_after;
   logic [CW-1:0] hold_cnt;
   logic          hold_v;
   logic          flush_pend;

   logic ready;
   logic accept;
   logic push;
   logic hold_free;
   logic flush_req;
   logic flush_go;
   logic xfer;

   always_comb begin
      ready     = !rst && (cnt < FULL_CNT) && !flush_pend;
      accept    = bus.in_valid && ready;
      push      = hold_v && !bus.fifo_full && !rst;
      hold_free = !hold_v || push;
      cnt_after = cnt + {{(CW-1){1'b0}}, accept};

      acc_after = acc;
      for (int i = 0; i < RATIO; i++) begin
         if (accept && (cnt == CW'(i))) begin
            acc_after[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
         end
      end

      // A second flush while one is pending merges into it.
      flush_req = bus.flush || flush_pend;
      flush_go  = flush_req && hold_free && (cnt_after != '0);
      xfer      = hold_free && ((cnt_after == FULL_CNT) || flush_go);
   end

   assign bus.in_ready   = ready;
   assign bus.fifo_push  = push;
   assign bus.fifo_wdata = rst ? '0 : hold_data;
   assign bus.fifo_cnt   = rst ? '0 : hold_cnt;
   assign bus.busy       = !rst && ((cnt != '0) || hold_v || flush_pend);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         cnt        <= '0;
         hold_data  <= '0;
         hold_cnt   <= '0;
         hold_v     <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         // Empty flushes are dropped rather than parked.
         flush_pend <= flush_req && !hold_free && (cnt_after != '0);
         if (xfer) begin
            // Lanes above cnt_after are still zero since acc was cleared at the last transfer.
            hold_data <= acc_after;
            hold_cnt  <= cnt_after;
            hold_v    <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
         end else begin
            acc <= acc_after;
            cnt <= cnt_after;
            if (push) begin
               hold_v <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_stream_packer.sv
// Directed and randomized checks of stream_packer against a queue-based packing model.
// The model records every accepted byte and expects each packed word, in order, on the push port.
module tb_stream_packer;
   localparam int IN_WIDTH = 8;
   localparam int RATIO    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   stream_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus ();

   stream_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: bytes of the word being built, and the words expected on the push port.
   logic [7:0]  part[$];
   logic [31:0] exp_d[$];
   int          exp_c[$];

   always @(negedge clk) begin
      logic [31:0] w;
      if (rst) begin
         check("push_in_reset", bus.fifo_push, 1'b0);
         part.delete();
         exp_d.delete();
         exp_c.delete();
      end else begin
         if (bus.fifo_push) begin
            check("push_while_full", bus.fifo_full, 1'b0);
            if (exp_d.size() == 0) begin
               check("push_unexpected", 1'b1, 1'b0);
            end else begin
               check("push_data", bus.fifo_wdata, exp_d.pop_front());
               check("push_cnt", bus.fifo_cnt, exp_c.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) part.push_back(bus.in_data);
         if (part.size() == RATIO || (bus.flush && part.size() > 0)) begin
            w = '0;
            foreach (part[i]) w[i*8 +: 8] = part[i];
            exp_d.push_back(w);
            exp_c.push_back(part.size());
            part.delete();
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          n_acc;
      logic        got;
      logic [7:0]  cur;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.flush     = 1'b0;
      bus.fifo_full = 1'b0;

      // Reset state
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_wdata", bus.fifo_wdata, 32'h0);
      check("rst_cnt", bus.fifo_cnt, 3'd0);
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", bus.in_ready, 1'b1);
      check("post_rst_busy", bus.busy, 1'b0);

      // Basic pack
      for (int i = 0; i < 4; i++) begin
         step();
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(8'h11 * (i + 1));
         @(negedge clk);
         check("basic_ready", bus.in_ready, 1'b1);
         check("basic_no_early_push", bus.fifo_push, 1'b0);
      end
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("basic_push", bus.fifo_push, 1'b1);
      check("basic_wdata", bus.fifo_wdata, 32'h44332211);
      check("basic_cnt", bus.fifo_cnt, 3'd4);
      check("basic_ready_at_push", bus.in_ready, 1'b1);
      step();
      @(negedge clk);
      check("basic_single_push", bus.fifo_push, 1'b0);
      check("basic_idle", bus.busy, 1'b0);

      // Partial flush together with the third accept
      step(); bus.in_valid = 1'b1; bus.in_data = 8'hAA;
      step(); bus.in_data = 8'hBB;
      step(); bus.in_data = 8'hCC; bus.flush = 1'b1;
      step(); bus.in_valid = 1'b0; bus.flush = 1'b0;
      @(negedge clk);
      check("flush_push", bus.fifo_push, 1'b1);
      check("flush_wdata", bus.fifo_wdata, 32'h00CCBBAA);
      check("flush_cnt", bus.fifo_cnt, 3'd3);
      step();
      @(negedge clk);
      check("flush_busy_after", bus.busy, 1'b0);

      // Empty flush is dropped
      step(); bus.flush = 1'b1;
      @(negedge clk);
      check("empty_flush_busy", bus.busy, 1'b0);
      step(); bus.flush = 1'b0;
      @(negedge clk);
      check("empty_flush_no_push", bus.fifo_push, 1'b0);
      check("empty_flush_not_pending", bus.busy, 1'b0);

      // Full backpressure: 12 offered, 8 taken
      n_acc = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         bus.fifo_full = 1'b1;
         bus.in_valid  = 1'b1;
         bus.in_data   = 8'(8'h50 + n_acc);
         @(negedge clk);
         check("full_no_push", bus.fifo_push, 1'b0);
         if (bus.in_ready) n_acc++;
      end
      check("full_accept_count", n_acc, 8);
      check("full_ready_low", bus.in_ready, 1'b0);
      step(); bus.fifo_full = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      check("release_push0", bus.fifo_push, 1'b1);
      check("release_wdata0", bus.fifo_wdata, 32'h53525150);
      step();
      @(negedge clk);
      check("release_push1", bus.fifo_push, 1'b1);
      check("release_wdata1", bus.fifo_wdata, 32'h57565554);
      check("release_ready", bus.in_ready, 1'b1);
      step();
      @(negedge clk);
      check("release_idle", bus.busy, 1'b0);

      // Flush while the hold slot is blocked by a full FIFO
      bus.fifo_full = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(8'h60 + i);
         step();
      end
      bus.in_valid = 1'b0; bus.flush = 1'b1;
      step();
      bus.flush = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h66;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("pend_ready_low", bus.in_ready, 1'b0);
         check("pend_busy", bus.busy, 1'b1);
         check("pend_no_push", bus.fifo_push, 1'b0);
         step();
      end
      bus.fifo_full = 1'b0;
      @(negedge clk);
      check("pend_push_held", bus.fifo_wdata, 32'h63626160);
      check("pend_push_held_v", bus.fifo_push, 1'b1);
      check("pend_ready_still_low", bus.in_ready, 1'b0);
      step();
      @(negedge clk);
      check("pend_push_part_v", bus.fifo_push, 1'b1);
      check("pend_push_part", bus.fifo_wdata, 32'h00006564);
      check("pend_push_part_cnt", bus.fifo_cnt, 3'd2);
      check("pend_resume", bus.in_ready, 1'b1);
      step(); bus.in_valid = 1'b0; bus.flush = 1'b1;
      step(); bus.flush = 1'b0;
      @(negedge clk);
      check("tail_push", bus.fifo_wdata, 32'h00000066);
      check("tail_cnt", bus.fifo_cnt, 3'd1);

      // Reset in the middle of a word
      for (int i = 0; i < 3; i++) begin
         step(); bus.in_valid = 1'b1; bus.in_data = 8'(8'h71 + i);
      end
      step(); bus.in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_ready", bus.in_ready, 1'b0);
      step(); rst = 1'b0;
      @(negedge clk);
      check("midrst_after_busy", bus.busy, 1'b0);
      check("midrst_after_push", bus.fifo_push, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(); bus.in_valid = 1'b1; bus.in_data = 8'(8'h81 + i);
      end
      step(); bus.in_valid = 1'b0;
      @(negedge clk);
      check("midrst_pack_push", bus.fifo_push, 1'b1);
      check("midrst_pack_wdata", bus.fifo_wdata, 32'h84838281);
      check("midrst_pack_cnt", bus.fifo_cnt, 3'd4);

      // Randomized traffic; data only changes after it has been taken
      cur = 8'($urandom);
      got = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (got) cur = 8'($urandom);
         bus.in_data   = cur;
         bus.in_valid  = ($urandom_range(3) != 0);
         bus.flush     = ($urandom_range(7) == 0);
         bus.fifo_full = ($urandom_range(2) == 0);
         @(negedge clk);
         got = bus.in_valid && bus.in_ready;
      end
      step();
      bus.in_valid = 1'b0; bus.fifo_full = 1'b0; bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
         step();
      end
      check("drain_idle", bus.busy, 1'b0);
      check("drain_all_pushed", exp_d.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
